// File: rtl/run_sequencer.sv
// Run sequencer for the 9-bit core: start handshake, core reset pulse,
// PC entry load, run gating with cycle count, halt/timeout and done report.
// Ports:
//   clk, reset (async, active-high)
//   start, prog_sel[1:0], halt                      : inputs
//   core_reset, pc_load, pc_load_addr[PC_W-1:0]     : core control outputs
//   run_en, done, timeout                           : run status outputs
//   cycle_count[CNT_W-1:0], prog_id[1:0]            : run status outputs
module run_sequencer #(
    parameter int              PC_W         = 10,
    parameter int              CNT_W        = 16,
    parameter int              RESET_CYCLES = 2,
    parameter logic [PC_W-1:0] START_ADDR0  = 10'h000,
    parameter logic [PC_W-1:0] START_ADDR1  = 10'h080,
    parameter logic [PC_W-1:0] START_ADDR2  = 10'h100,
    parameter logic [PC_W-1:0] START_ADDR3  = 10'h180,
    parameter int              MAX_CYCLES   = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       prog_sel,
    input  logic             halt,
    output logic             core_reset,
    output logic             pc_load,
    output logic [PC_W-1:0]  pc_load_addr,
    output logic             run_en,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [1:0]       prog_id
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CLR  = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam logic [3:0]       RST_LOAD = 4'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic             start_q;
    logic             start_edge;
    logic             accept;
    logic [3:0]       rst_cnt_q, rst_cnt_d;
    logic             core_reset_q, core_reset_d;
    logic             pc_load_q, pc_load_d;
    logic [PC_W-1:0]  pc_load_addr_q, pc_load_addr_d;
    logic             run_en_q, run_en_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [1:0]       prog_id_q, prog_id_d;
    logic [PC_W-1:0]  entry_addr;

    assign start_edge = start & ~start_q;
    // A start edge is only honoured when no run is in flight.
    assign accept = start_edge &&
                    (state_q == S_IDLE || state_q == S_FIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            start_q        <= 1'b0;
            rst_cnt_q      <= 4'd0;
            core_reset_q   <= 1'b0;
            pc_load_q      <= 1'b0;
            pc_load_addr_q <= START_ADDR0;
            run_en_q       <= 1'b0;
            done_q         <= 1'b0;
            timeout_q      <= 1'b0;
            cycle_count_q  <= '0;
            prog_id_q      <= 2'd0;
        end else begin
            state_q        <= state_d;
            start_q        <= start;
            rst_cnt_q      <= rst_cnt_d;
            core_reset_q   <= core_reset_d;
            pc_load_q      <= pc_load_d;
            pc_load_addr_q <= pc_load_addr_d;
            run_en_q       <= run_en_d;
            done_q         <= done_d;
            timeout_q      <= timeout_d;
            cycle_count_q  <= cycle_count_d;
            prog_id_q      <= prog_id_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        case (state_q)
            S_IDLE, S_FIN: begin
                if (start_edge) begin
                    state_d   = S_CLR;
                    rst_cnt_d = RST_LOAD;
                end
            end
            S_CLR: begin
                if (rst_cnt_q == 4'd0) begin
                    state_d = S_LOAD;
                end else begin
                    rst_cnt_d = rst_cnt_q - 4'd1;
                end
            end
            S_LOAD:  state_d = S_RUN;
            S_RUN: begin
                if (halt || cycle_count_q == CNT_LAST) begin
                    state_d = S_FIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (prog_id_q)
            2'd0:    entry_addr = START_ADDR0;
            2'd1:    entry_addr = START_ADDR1;
            2'd2:    entry_addr = START_ADDR2;
            default: entry_addr = START_ADDR3;
        endcase
    end

    // Outputs are registered from the next state so they line up
    // with the state they describe.
    always_comb begin
        core_reset_d   = (state_d == S_CLR);
        pc_load_d      = (state_d == S_LOAD);
        run_en_d       = (state_d == S_RUN);
        done_d         = (state_d == S_FIN);
        pc_load_addr_d = pc_load_addr_q;
        prog_id_d      = prog_id_q;
        cycle_count_d  = cycle_count_q;
        timeout_d      = timeout_q;
        if (accept) begin
            prog_id_d     = prog_sel;
            cycle_count_d = '0;
            timeout_d     = 1'b0;
        end else if (state_q == S_RUN) begin
            cycle_count_d = cycle_count_q + CNT_ONE;
            if (state_d == S_FIN) begin
                timeout_d = ~halt;
            end
        end
        if (state_q == S_CLR && state_d == S_LOAD) begin
            pc_load_addr_d = entry_addr;
        end
    end

    assign core_reset   = core_reset_q;
    assign pc_load      = pc_load_q;
    assign pc_load_addr = pc_load_addr_q;
    assign run_en       = run_en_q;
    assign done         = done_q;
    assign timeout      = timeout_q;
    assign cycle_count  = cycle_count_q;
    assign prog_id      = prog_id_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: timeline reference model,
// per-cycle compare, directed literal checks and random stimulus.
module tb_run_sequencer;

    localparam int R    = 2;
    localparam int MAXC = 20;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  prog_sel;
    logic        halt;
    logic        core_reset;
    logic        pc_load;
    logic [9:0]  pc_load_addr;
    logic        run_en;
    logic        done;
    logic        timeout;
    logic [15:0] cycle_count;
    logic [1:0]  prog_id;

    int checks = 0;
    int errors = 0;
    bit go = 0;

    run_sequencer #(
        .RESET_CYCLES(R),
        .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk),
        .reset(rst),
        .start(start),
        .prog_sel(prog_sel),
        .halt(halt),
        .core_reset(core_reset),
        .pc_load(pc_load),
        .pc_load_addr(pc_load_addr),
        .run_en(run_en),
        .done(done),
        .timeout(timeout),
        .cycle_count(cycle_count),
        .prog_id(prog_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] entry(input logic [1:0] s);
        return 10'(s) * 10'h080;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a run is a timeline measured in edges since the
    // accepted start; m_cnt counts RUN cycles until halt or the limit.
    bit         m_prev, m_busy, m_done, m_to;
    int         m_p, m_cnt;
    logic [1:0] m_prog;
    logic [9:0] m_addr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prev <= 0; m_busy <= 0; m_p <= 0; m_cnt <= 0;
            m_done <= 0; m_to <= 0; m_prog <= 0; m_addr <= 10'h000;
        end else begin
            m_prev <= start;
            if (m_busy) begin
                m_p <= m_p + 1;
                if (m_p > R) begin
                    m_cnt <= m_cnt + 1;
                    if (halt || m_cnt + 1 == MAXC) begin
                        m_busy <= 0;
                        m_done <= 1;
                        m_to   <= !halt;
                    end
                end
            end else if (start && !m_prev) begin
                m_busy <= 1; m_p <= 0; m_cnt <= 0;
                m_done <= 0; m_to <= 0;
                m_prog <= prog_sel;
                m_addr <= entry(prog_sel);
            end
        end
    end

    always @(negedge clk) begin
        if (go) begin
            chk("core_reset", core_reset, m_busy && m_p < R);
            chk("pc_load", pc_load, m_busy && m_p == R);
            chk("run_en", run_en, m_busy && m_p > R);
            chk("done", done, m_done);
            chk("timeout", timeout, m_to);
            chk("cycle_count", cycle_count, m_cnt);
            chk("prog_id", prog_id, m_prog);
            if (m_busy && m_p == R)
                chk("pc_load_addr", pc_load_addr, m_addr);
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_run;
        int n = 0;
        while (!run_en && n < 30) begin
            tick;
            n++;
        end
        chk("run_reached", run_en, 1);
    endtask

    task automatic wait_done;
        int n = 0;
        while (!done && n < 60) begin
            tick;
            n++;
        end
        chk("done_reached", done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; start = 0; prog_sel = 0; halt = 0;
        tick;
        go = 1;
        tick;
        chk("rst_run_en", run_en, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", pc_load_addr, 10'h000);
        chk("rst_cnt", cycle_count, 0);
        rst = 0;
        tick;

        // first run, prog 1, halt on 5th RUN cycle
        prog_sel = 1; start = 1;
        tick;
        chk("t1_cr1", core_reset, 1);
        chk("t1_prog", prog_id, 1);
        tick;
        chk("t1_cr2", core_reset, 1);
        tick;
        chk("t1_load", pc_load, 1);
        chk("t1_cr_off", core_reset, 0);
        chk("t1_addr", pc_load_addr, 10'h080);
        tick;
        chk("t1_run", run_en, 1);
        chk("t1_load_off", pc_load, 0);
        repeat (4) tick;
        halt = 1;
        tick;
        halt = 0;
        chk("t2_done", done, 1);
        chk("t2_to", timeout, 0);
        chk("t2_cnt", cycle_count, 5);
        chk("t2_run_off", run_en, 0);
        start = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("t2_done_hold", done, 1);
        end

        // timeout, then halt exactly on the limit cycle
        prog_sel = 2; start = 1;
        wait_run;
        wait_done;
        chk("t3_cnt", cycle_count, 20);
        chk("t3_to", timeout, 1);
        start = 0;
        tick;
        start = 1;
        wait_run;
        repeat (19) tick;
        halt = 1;
        tick;
        halt = 0;
        chk("t3b_done", done, 1);
        chk("t3b_to", timeout, 0);
        chk("t3b_cnt", cycle_count, 20);

        // start toggles during CLR and RUN are ignored
        start = 0;
        tick;
        prog_sel = 0; start = 1;
        tick;
        start = 0;
        tick;
        start = 1;
        tick;
        wait_run;
        start = 0;
        tick;
        start = 1;
        tick;
        halt = 1;
        tick;
        halt = 0;
        chk("t4_done", done, 1);
        chk("t4_cnt", cycle_count, 3);
        chk("t4_prog", prog_id, 0);

        // restart from FIN with prog 3
        start = 0;
        tick;
        prog_sel = 3; start = 1;
        tick;
        chk("t5_done_fall", done, 0);
        chk("t5_cnt0", cycle_count, 0);
        chk("t5_prog", prog_id, 3);
        tick;
        tick;
        chk("t5_load", pc_load, 1);
        chk("t5_addr", pc_load_addr, 10'h180);
        tick;
        chk("t5_run", run_en, 1);
        repeat (7) tick;
        chk("t5_cnt7", cycle_count, 7);

        // async reset mid-run, start held high across release
        #1 rst = 1;
        #1;
        chk("ar_run_en", run_en, 0);
        chk("ar_cnt", cycle_count, 0);
        chk("ar_done", done, 0);
        tick;
        rst = 0;
        tick;
        chk("ar_restart", core_reset, 1);

        // halt ignored in IDLE, CLR and LOAD
        rst = 1;
        tick;
        start = 0; halt = 1;
        rst = 0;
        tick;
        tick;
        chk("h_idle_done", done, 0);
        chk("h_idle_cr", core_reset, 0);
        start = 1;
        repeat (4) tick;
        chk("h_run", run_en, 1);
        chk("h_not_done", done, 0);
        halt = 0;
        tick;
        halt = 1;
        tick;
        halt = 0;
        chk("h_cnt", cycle_count, 2);
        chk("h_done", done, 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            tick;
            if ($urandom_range(0, 7) == 0) start = ~start;
            prog_sel = 2'($urandom);
            halt = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1;
                tick;
                rst = 0;
            end
        end
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
